// File: rtl/branch_checkpoint_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_checkpoint_unit
// Brief    : Checkpoint table for speculative branches. Snapshots rename map,
//            free-list head and active-list position per renamed branch,
//            releases on correct resolution, and emits a registered one-cycle
//            recovery packet (squashing younger checkpoints) on a mispredict.
//            Optional feature macro: BRANCH_DELAY_SLOT_EN (stores the delay
//            slot flag and extends the kill boundary past the delay slot).
// Revision : 1.0 - initial release
// ============================================================================
module branch_checkpoint_unit #(
    parameter  int DEPTH     = 4,
    parameter  int ARCH_REGS = 32,
    parameter  int PREG_W    = 6,
    parameter  int AL_W      = 5,
    localparam int TAG_W     = $clog2(DEPTH),
    localparam int MAP_W     = ARCH_REGS * PREG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [AL_W-1:0]   alloc_al_id,
    input  logic              alloc_color,
    input  logic              alloc_ds,
    input  logic [MAP_W-1:0]  alloc_map,
    input  logic [PREG_W-1:0] alloc_free_head,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              resolve_valid,
    input  logic [TAG_W-1:0]  resolve_tag,
    input  logic              resolve_miss,
    output logic              recover_valid,
    output logic [MAP_W-1:0]  recover_map,
    output logic [PREG_W-1:0] recover_free_head,
    output logic [AL_W-1:0]   recover_youngest,
    output logic              recover_color,
    output logic [AL_W-1:0]   kill_al_id,
    output logic              kill_color,
    output logic [TAG_W:0]    occupancy
);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_RECOVER = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              w_idle;

    // Per-slot storage; only valid needs reset, payload is qualified by it.
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  w_valid_nxt;
    logic [AL_W-1:0]   r_al_id     [DEPTH];
    logic              r_color     [DEPTH];
    logic [MAP_W-1:0]  r_map       [DEPTH];
    logic [PREG_W-1:0] r_free_head [DEPTH];

    logic              w_free_found;
    logic [TAG_W-1:0]  w_free_idx;
    logic              w_resolve_hit;
    logic              w_miss;
    logic              w_alloc_fire;
    logic [AL_W-1:0]   w_tag_al;
    logic              w_tag_color;
    logic              w_tag_ds;
    logic [AL_W-1:0]   w_bound;
    logic              w_bound_color;
    logic [DEPTH-1:0]  w_younger;

`ifdef BRANCH_DELAY_SLOT_EN
    logic              r_ds [DEPTH];
    assign w_tag_ds = r_ds[resolve_tag];
`else
    // Delay-slot flag has no meaning in this build.
    logic              w_unused_ds;
    assign w_unused_ds = alloc_ds;
    assign w_tag_ds    = 1'b0;
`endif

    // Resolves are only honoured in IDLE and only against a live checkpoint.
    assign w_resolve_hit = w_idle && resolve_valid && r_valid[resolve_tag];
    assign w_miss        = w_resolve_hit && resolve_miss;
    // A mispredict in the same cycle wins over the allocation.
    assign w_alloc_fire  = alloc_valid && alloc_ready && !w_miss;

    // Kill boundary: the branch itself, or its delay slot if it has one.
    assign w_tag_al      = r_al_id[resolve_tag];
    assign w_tag_color   = r_color[resolve_tag];
    assign w_bound       = w_tag_al + AL_W'(w_tag_ds);
    assign w_bound_color = w_tag_color ^ (w_tag_ds & (&w_tag_al));

    // Lowest-index free slot (scan downward so the lowest index wins).
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = TAG_W'(i);
            end
        end
    end

    // Age comparison of every slot against the kill boundary, colour-aware.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_younger[i] = (r_color[i] == w_bound_color) ? (r_al_id[i] > w_bound)
                                                         : (r_al_id[i] < w_bound);
        end
    end

    // Next valid vector: allocate, release, or squash on mispredict.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_alloc_fire)
            w_valid_nxt[w_free_idx] = 1'b1;
        if (w_resolve_hit) begin
            w_valid_nxt[resolve_tag] = 1'b0;
            if (resolve_miss)
                w_valid_nxt = w_valid_nxt & ~w_younger;
        end
    end

    // Valid bits register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_valid <= '0;
        else        r_valid <= w_valid_nxt;
    end

    // Slot payload capture on an accepted allocation.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_al_id[w_free_idx]     <= alloc_al_id;
            r_color[w_free_idx]     <= alloc_color;
            r_map[w_free_idx]       <= alloc_map;
            r_free_head[w_free_idx] <= alloc_free_head;
`ifdef BRANCH_DELAY_SLOT_EN
            r_ds[w_free_idx]        <= alloc_ds;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state: RECOVER always lasts a single cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (w_miss) w_state_nxt = c_RECOVER;
            c_RECOVER: w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_idle      = (r_state == c_IDLE);
        alloc_ready = w_idle && w_free_found;
        alloc_tag   = w_free_idx;
    end

    // Recovery packet; payload holds its value between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recover_valid     <= 1'b0;
            recover_map       <= '0;
            recover_free_head <= '0;
            recover_youngest  <= '0;
            recover_color     <= 1'b0;
            kill_al_id        <= '0;
            kill_color        <= 1'b0;
        end else begin
            recover_valid <= w_miss;
            if (w_miss) begin
                recover_map       <= r_map[resolve_tag];
                recover_free_head <= r_free_head[resolve_tag];
                recover_youngest  <= w_bound + AL_W'(1);
                recover_color     <= w_bound_color ^ (&w_bound);
                kill_al_id        <= w_bound;
                kill_color        <= w_bound_color;
            end
        end
    end

    // Population count of live checkpoints.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++)
            occupancy = occupancy + (TAG_W + 1)'(r_valid[i]);
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_checkpoint_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_checkpoint_unit
// Brief    : Directed self-checking bench for branch_checkpoint_unit
//            (DEPTH=4, ARCH_REGS=32, PREG_W=6, AL_W=5). Wrap-case expectations
//            follow BRANCH_DELAY_SLOT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_checkpoint_unit;

    localparam int MAP_W = 32 * 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [4:0]       alloc_al_id;
    logic             alloc_color;
    logic             alloc_ds;
    logic [MAP_W-1:0] alloc_map;
    logic [5:0]       alloc_free_head;
    logic [1:0]       alloc_tag;
    logic             resolve_valid;
    logic [1:0]       resolve_tag;
    logic             resolve_miss;
    logic             recover_valid;
    logic [MAP_W-1:0] recover_map;
    logic [5:0]       recover_free_head;
    logic [4:0]       recover_youngest;
    logic             recover_color;
    logic [4:0]       kill_al_id;
    logic             kill_color;
    logic [2:0]       occupancy;

    int total = 0;
    int bad   = 0;

    branch_checkpoint_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .alloc_al_id       (alloc_al_id),
        .alloc_color       (alloc_color),
        .alloc_ds          (alloc_ds),
        .alloc_map         (alloc_map),
        .alloc_free_head   (alloc_free_head),
        .alloc_tag         (alloc_tag),
        .resolve_valid     (resolve_valid),
        .resolve_tag       (resolve_tag),
        .resolve_miss      (resolve_miss),
        .recover_valid     (recover_valid),
        .recover_map       (recover_map),
        .recover_free_head (recover_free_head),
        .recover_youngest  (recover_youngest),
        .recover_color     (recover_color),
        .kill_al_id        (kill_al_id),
        .kill_color        (kill_color),
        .occupancy         (occupancy)
    );

    always #5 clk = ~clk;

    // Rename map pattern: register r maps to (seed + r) mod 64.
    function automatic logic [MAP_W-1:0] mk_map(input int seed);
        logic [MAP_W-1:0] m;
        m = '0;
        for (int r = 0; r < 32; r++)
            m[r*6 +: 6] = 6'((seed + r) % 64);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [MAP_W-1:0] obs,
                       input logic [MAP_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid     = 1'b0;
        alloc_al_id     = '0;
        alloc_color     = 1'b0;
        alloc_ds        = 1'b0;
        alloc_map       = '0;
        alloc_free_head = '0;
        resolve_valid   = 1'b0;
        resolve_tag     = '0;
        resolve_miss    = 1'b0;
    endtask

    // Advance one clock; sampling point is 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // Drive one allocation, check the granted tag before the edge, then clock.
    task automatic do_alloc(input logic [4:0] al, input logic col, input logic ds,
                            input int seed, input logic [1:0] exp_tag);
        alloc_valid     = 1'b1;
        alloc_al_id     = al;
        alloc_color     = col;
        alloc_ds        = ds;
        alloc_map       = mk_map(seed);
        alloc_free_head = 6'(seed + 1);
        #1;
        chk("alloc_ready_pre", MAP_W'(alloc_ready), MAP_W'(1));
        chk("alloc_tag_pre",   MAP_W'(alloc_tag),   MAP_W'(exp_tag));
        tick();
        idle_inputs();
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        // Reset values
        chk("rst_recover_valid", MAP_W'(recover_valid), MAP_W'(0));
        chk("rst_occupancy",     MAP_W'(occupancy),     MAP_W'(0));
        chk("rst_alloc_ready",   MAP_W'(alloc_ready),   MAP_W'(1));
        chk("rst_alloc_tag",     MAP_W'(alloc_tag),     MAP_W'(0));
        chk("rst_recover_map",   recover_map,           MAP_W'(0));
        chk("rst_kill_al_id",    MAP_W'(kill_al_id),    MAP_W'(0));
        do_reset();

        // Fill the table: tags 0..3
        for (int k = 0; k < 4; k++)
            do_alloc(5'(k), 1'b0, 1'b0, 4 * k, 2'(k));
        chk("full_occupancy",   MAP_W'(occupancy),   MAP_W'(4));
        chk("full_alloc_ready", MAP_W'(alloc_ready), MAP_W'(0));
        alloc_valid = 1'b1;
        tick();
        idle_inputs();
        chk("fifth_alloc_ignored", MAP_W'(occupancy), MAP_W'(4));

        // Correct resolve of tag 0 together with alloc while full
        alloc_valid   = 1'b1;
        alloc_al_id   = 5'd20;
        resolve_valid = 1'b1;
        resolve_tag   = 2'd0;
        resolve_miss  = 1'b0;
        tick();
        idle_inputs();
        #1;
        chk("res_alloc_occupancy", MAP_W'(occupancy),   MAP_W'(3));
        chk("res_alloc_tag_next",  MAP_W'(alloc_tag),   MAP_W'(0));
        chk("res_alloc_ready",     MAP_W'(alloc_ready), MAP_W'(1));

        // Mispredict at al_id 7 with a same-cycle allocation
        do_reset();
        do_alloc(5'd3,  1'b0, 1'b0, 10, 2'd0);
        do_alloc(5'd7,  1'b0, 1'b0, 20, 2'd1);
        do_alloc(5'd12, 1'b0, 1'b0, 30, 2'd2);
        alloc_valid   = 1'b1;
        alloc_al_id   = 5'd25;
        alloc_map     = mk_map(50);
        resolve_valid = 1'b1;
        resolve_tag   = 2'd1;
        resolve_miss  = 1'b1;
        tick();
        // Recovery cycle; a resolve here must be ignored
        idle_inputs();
        resolve_valid = 1'b1;
        resolve_tag   = 2'd0;
        chk("miss_recover_valid", MAP_W'(recover_valid),     MAP_W'(1));
        chk("miss_youngest",      MAP_W'(recover_youngest),  MAP_W'(8));
        chk("miss_recover_color", MAP_W'(recover_color),     MAP_W'(0));
        chk("miss_kill_al_id",    MAP_W'(kill_al_id),        MAP_W'(7));
        chk("miss_kill_color",    MAP_W'(kill_color),        MAP_W'(0));
        chk("miss_map",           recover_map,               mk_map(20));
        chk("miss_free_head",     MAP_W'(recover_free_head), MAP_W'(21));
        chk("miss_occupancy",     MAP_W'(occupancy),         MAP_W'(1));
        chk("miss_alloc_ready",   MAP_W'(alloc_ready),       MAP_W'(0));
        tick();
        idle_inputs();
        #1;
        chk("post_recover_valid", MAP_W'(recover_valid),    MAP_W'(0));
        chk("post_alloc_ready",   MAP_W'(alloc_ready),      MAP_W'(1));
        chk("post_alloc_tag",     MAP_W'(alloc_tag),        MAP_W'(1));
        chk("post_occupancy",     MAP_W'(occupancy),        MAP_W'(1));
        chk("post_payload_hold",  MAP_W'(recover_youngest), MAP_W'(8));

        // Mispredict resolve to an invalid tag is ignored
        resolve_valid = 1'b1;
        resolve_tag   = 2'd2;
        resolve_miss  = 1'b1;
        tick();
        idle_inputs();
        chk("inv_recover_valid", MAP_W'(recover_valid), MAP_W'(0));
        chk("inv_occupancy",     MAP_W'(occupancy),     MAP_W'(1));

        // Wrap-around case
        do_reset();
        do_alloc(5'd31, 1'b0, 1'b1, 40, 2'd0);
        do_alloc(5'd1,  1'b1, 1'b0, 44, 2'd1);
        do_alloc(5'd30, 1'b0, 1'b0, 48, 2'd2);
        resolve_valid = 1'b1;
        resolve_tag   = 2'd0;
        resolve_miss  = 1'b1;
        tick();
        idle_inputs();
        chk("wrap_recover_valid", MAP_W'(recover_valid), MAP_W'(1));
        chk("wrap_map",           recover_map,           mk_map(40));
`ifdef BRANCH_DELAY_SLOT_EN
        chk("wrap_youngest",      MAP_W'(recover_youngest), MAP_W'(1));
        chk("wrap_recover_color", MAP_W'(recover_color),    MAP_W'(1));
        chk("wrap_kill_al_id",    MAP_W'(kill_al_id),       MAP_W'(0));
        chk("wrap_kill_color",    MAP_W'(kill_color),       MAP_W'(1));
`else
        chk("wrap_youngest",      MAP_W'(recover_youngest), MAP_W'(0));
        chk("wrap_recover_color", MAP_W'(recover_color),    MAP_W'(1));
        chk("wrap_kill_al_id",    MAP_W'(kill_al_id),       MAP_W'(31));
        chk("wrap_kill_color",    MAP_W'(kill_color),       MAP_W'(0));
`endif
        chk("wrap_occupancy",     MAP_W'(occupancy),        MAP_W'(1));
        chk("wrap_free_tag",      MAP_W'(alloc_tag),        MAP_W'(0));

        // Reset asserted during the recovery cycle
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstrec_recover_valid", MAP_W'(recover_valid), MAP_W'(0));
        chk("rstrec_occupancy",     MAP_W'(occupancy),     MAP_W'(0));
        chk("rstrec_alloc_ready",   MAP_W'(alloc_ready),   MAP_W'(1));
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_checkpoint_unit.md
# branch_checkpoint_unit

Parametrised checkpoint table for speculative branches. It sits between rename and the active list. On every renamed branch it snapshots the rename map, the free-list head and the branch's active-list position. On a correct resolution it releases the snapshot. On a misprediction it drives a registered one-cycle recovery packet: restored map, free head, new youngest pointer and kill boundary. It also squashes every younger checkpoint. It generalises the previous fixed-size misprediction logic to configurable depth and widths, out-of-order resolution, and per-entry stored colour bits.

## Interface
- DEPTH, 4: number of checkpoints; power of 2, ≥2; TAG_W = $clog2(DEPTH)
- ARCH_REGS, 32: architectural registers in the map
- PREG_W, 6: physical register index width
- AL_W, 5: active-list index width; list size 2^AL_W
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  branch renamed this cycle, take a checkpoint
- alloc_ready  out  1  a checkpoint can be accepted
- alloc_al_id  in  AL_W  active-list id of the branch
- alloc_color  in  1  colour bit of the branch
- alloc_ds  in  1  branch has a delay slot already in the active list
- alloc_map  in  ARCH_REGS*PREG_W  flattened rename map, reg r at [r*PREG_W +: PREG_W]
- alloc_free_head  in  PREG_W  free-list head pointer
- alloc_tag  out  TAG_W  slot granted to the current alloc
- resolve_valid  in  1  branch resolved
- resolve_tag  in  TAG_W  checkpoint of the resolved branch
- resolve_miss  in  1  the resolved branch was mispredicted
- recover_valid  out  1  one-cycle recovery pulse
- recover_map  out  ARCH_REGS*PREG_W  restored rename map
- recover_free_head  out  PREG_W  restored free head
- recover_youngest  out  AL_W  new active-list youngest pointer
- recover_color  out  1  new global colour bit
- kill_al_id  out  AL_W  last surviving active-list id; anything younger is squashed
- kill_color  out  1  colour of kill_al_id
- occupancy  out  TAG_W+1  valid checkpoints

## Operation
- **State:** per slot it holds valid, al_id, color, ds, map and free_head. FSM has two states, IDLE and RECOVER.
- **Allocate:**
  - alloc_ready = (state==IDLE) && any slot free.
  - alloc_tag = lowest-index free slot, evaluated on the pre-edge valid vector.
  - A handshake (alloc_valid && alloc_ready) writes the slot and sets valid at the edge.
- **Resolve correct** (resolve_valid && !resolve_miss && valid[tag]): clears valid[tag].
- **Resolve miss** (resolve_valid && resolve_miss && valid[tag]), taken only in IDLE:
  - Boundary B = al_id + ds (mod 2^AL_W). Boundary colour CB = color, inverted if ds and al_id == all-ones.
  - Clear valid[tag], and clear valid[i] for every slot i younger than (B, CB). Slot i is younger when color_i==CB && al_id_i>B, or color_i!=CB && al_id_i<B.
  - Register the recovery outputs from slot tag, go to RECOVER.
- **Recovery outputs:**
  - recover_map = map[tag]; recover_free_head = free_head[tag].
  - recover_youngest = B+1 (mod); recover_color = CB, inverted if B == all-ones.
  - kill_al_id = B; kill_color = CB.
- **RECOVER:** lasts exactly one cycle and returns to IDLE. alloc_ready=0; resolve inputs are ignored.
- **Invalid resolves:** a resolve to an invalid tag is ignored.
- **Simultaneous events:**
  - A valid miss beats a same-cycle allocation: the allocation is dropped and no slot is written.
  - Correct resolve with alloc in the same cycle: both take effect. The freed slot is not re-granted that cycle.
- **Reset:** all valid=0, state=IDLE. Reset asserted mid-recovery aborts it; recover_valid drops asynchronously.

## Timing
- Allocate and resolve update state at the clock edge; alloc_tag and alloc_ready are combinational from current state.
- Miss sampled at edge N → recover_valid=1 during cycle N+1 only. Squashed valids are already cleared in cycle N+1. alloc_ready=0 in cycle N+1 and returns in N+2.
- Reset values of outputs:
  - recover_valid=0, recover_map=0, recover_free_head=0, recover_youngest=0, recover_color=0, kill_al_id=0, kill_color=0, occupancy=0.
  - alloc_ready=1 and alloc_tag=0, since they are combinational from an empty table.
- Recovery payload registers hold their last value when recover_valid=0.
- Full: occupancy==DEPTH → alloc_ready=0; alloc_valid is ignored.
- Wrap-around: all al_id arithmetic is mod 2^AL_W. Colour flips when an increment crosses all-ones → 0.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: the ds field is stored and B = al_id + ds, as above.
- Not defined: alloc_ds is ignored and the ds storage is removed; B = al_id and CB = color.

## Test plan
- Reset, then 4 allocs (DEPTH=4) → tags 0,1,2,3, occupancy=4, alloc_ready=0; a fifth alloc is ignored.
- Allocs at al_id 3,7,12 (colour 0); miss on tag 1 with ds=0 → next cycle recover_valid=1, recover_youngest=8, kill_al_id=7, map/free_head of tag 1 restored; slots 1 and 2 invalid, occupancy=1.
- Wrap case: branch al_id=31, colour 0, ds=1, younger entry al_id=1 colour 1; miss (macro on) → B=0, CB=1, recover_youngest=1, recover_color=1, younger slot squashed. Macro off → B=31, recover_youngest=0, recover_color=1.
- Correct resolve of tag 0 concurrent with alloc while full-minus-zero → alloc rejected that cycle; next cycle alloc_tag=0.
- Miss and alloc_valid in the same cycle → no slot written; alloc_ready=0 during the recovery cycle, 1 the cycle after.
- rst_n asserted during the recovery cycle → recover_valid=0 immediately, occupancy=0, alloc_ready=1.
